// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain: depth limit,
// occupancy width helper and the default-width entry record.
package pipe_pkg;

    localparam int PIPE_DEPTH_MAX = 8;
    localparam int PIPE_LEN_DEF   = 32;
    localparam int PIPE_WIDTH_DEF = 64;

    typedef struct packed {
        logic [PIPE_LEN_DEF-1:0]   pc;
        logic [PIPE_WIDTH_DEF-1:0] data;
    } pipe_entry_t;

    // A chain of `depth` slots holds up to 2*depth entries.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One two-entry skid slot: main drives the output, skid absorbs one entry of
// back-pressure so in_ready depends only on local state.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int LEN   = PIPE_LEN_DEF,
    parameter int WIDTH = PIPE_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_pc,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_pc,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef struct packed {
        logic [LEN-1:0]   pc;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t in_e;
    entry_t m_q, m_d, s_q, s_d;
    logic   m_v_q, m_v_d, s_v_q, s_v_d;
    logic   acc, take;

    assign in_e = {in_pc, in_data};
    assign acc  = in_valid & ~s_v_q;
    assign take = m_v_q & out_ready;

    always_comb begin
        m_v_d = m_v_q;
        s_v_d = s_v_q;
        m_d   = m_q;
        s_d   = s_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (take || !m_v_q) begin
            if (s_v_q) begin
                m_d   = s_q;
                m_v_d = 1'b1;
                s_v_d = 1'b0;
            end else begin
                // Only load payload on accept so idle outputs stay at their last value.
                if (acc) m_d = in_e;
                m_v_d = acc;
            end
        end else if (acc) begin
            s_d   = in_e;
            s_v_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
            m_q   <= m_d;
            s_q   <= s_d;
        end
    end

    assign in_ready  = ~s_v_q;
    assign out_valid = m_v_q;
    assign out_pc    = m_q.pc;
    assign out_data  = m_q.data;
    assign count     = {1'b0, m_v_q} + {1'b0, s_v_q};

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH chained skid slots carrying {pc, payload} with valid/ready handshake
// and synchronous flush. Define PIPE_STAGE_CHAIN_PERF_EN for stall/flush counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter  int LEN   = PIPE_LEN_DEF,
    parameter  int WIDTH = PIPE_WIDTH_DEF,
    parameter  int DEPTH = 1,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_pc,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_pc,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH:0]            v, r;
    logic [DEPTH:0][LEN-1:0]   pc;
    logic [DEPTH:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][1:0]     cnt;
    logic [OCC_W-1:0]          occ_sum;

    assign v[0]     = in_valid;
    assign pc[0]    = in_pc;
    assign data[0]  = in_data;
    assign in_ready = r[0];
    assign r[DEPTH] = out_ready;
    assign out_valid = v[DEPTH];
    assign out_pc    = pc[DEPTH];
    assign out_data  = data[DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_slot #(.LEN(LEN), .WIDTH(WIDTH)) u_slot (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (v[k]),
            .in_ready  (r[k]),
            .in_pc     (pc[k]),
            .in_data   (data[k]),
            .out_valid (v[k+1]),
            .out_ready (r[k+1]),
            .out_pc    (pc[k+1]),
            .out_data  (data[k+1]),
            .count     (cnt[k])
        );
    end

    // Sum of per-slot counts; each count is a pure function of slot flops.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < DEPTH; k++) occ_sum = occ_sum + OCC_W'(cnt[k]);
    end
    assign occupancy = occ_sum;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] stall_q, stall_d, flush_q, flush_d;
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flush_q} + 33'(occ_sum);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
        if (flush) flush_d = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: DEPTH=3 (latency, flush, random
// scoreboard) and DEPTH=2 (capacity, back-pressure, async reset).
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0, a_ir, a_ov;
    logic [31:0] a_ipc = '0, a_opc;
    logic [63:0] a_id = '0, a_od;
    logic [2:0]  a_occ;

    logic        b_flush = 1'b0, b_iv = 1'b0, b_or = 1'b0, b_ir, b_ov;
    logic [31:0] b_ipc = '0, b_opc;
    logic [63:0] b_id = '0, b_od;
    logic [2:0]  b_occ;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] a_stall, a_fcnt, b_stall, b_fcnt;
`endif

    pipe_stage_chain #(.LEN(32), .WIDTH(64), .DEPTH(3)) u_a (
        .clock(clk), .reset(rst), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_pc(a_ipc), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_pc(a_opc), .out_data(a_od),
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        .stall_cnt(a_stall), .flush_cnt(a_fcnt),
`endif
        .occupancy(a_occ)
    );

    pipe_stage_chain #(.LEN(32), .WIDTH(64), .DEPTH(2)) u_b (
        .clock(clk), .reset(rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_pc(b_ipc), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_pc(b_opc), .out_data(b_od),
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        .stall_cnt(b_stall), .flush_cnt(b_fcnt),
`endif
        .occupancy(b_occ)
    );

    function automatic logic [63:0] dat(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_5A5A, ~pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, oidx, stall_model;
        logic        acc_prev, ir_b;
        logic [31:0] pcn;
        logic [31:0] q[$];

        // Reset state on both chains.
        @(negedge clk);
        chk("rst_a_ov", a_ov, 0);   chk("rst_a_ir", a_ir, 1);
        chk("rst_a_pc", a_opc, 0);  chk("rst_a_dat", a_od, 0);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_b_ov", b_ov, 0);   chk("rst_b_ir", b_ir, 1);
        chk("rst_b_occ", b_occ, 0);
        rst = 1'b0;

        // DEPTH=3 streaming: 3-edge latency then back-to-back PCs.
        a_or = 1'b1;
        a_iv = 1'b1;
        for (int n = 0; n < 9; n++) begin
            if (n > 0) @(negedge clk);
            chk("lat_ov", a_ov, n >= 3);
            chk("lat_occ", a_occ, (n < 3) ? n : 3);
            chk("lat_ir", a_ir, 1);
            if (n >= 3) begin
                chk("lat_pc", a_opc, 32'(4 * (n - 3)));
                chk("lat_dat", a_od, dat(32'(4 * (n - 3))));
            end
            a_ipc = 32'(4 * n);
            a_id  = dat(a_ipc);
        end

        // Flush with 3 in flight and a new entry offered in the same cycle.
        @(negedge clk);
        chk("fl_occ_pre", a_occ, 3);
        a_flush = 1'b1;
        a_ipc   = 32'h1000;
        a_id    = dat(a_ipc);
        @(negedge clk);
        chk("fl_ov", a_ov, 0);
        chk("fl_occ", a_occ, 0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("fl_cnt", a_fcnt, 3);
`endif
        a_flush = 1'b0;
        a_iv    = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("fl_quiet", a_ov, 0);
        end
        a_iv  = 1'b1;
        a_ipc = 32'h2000;
        a_id  = dat(a_ipc);
        @(negedge clk);
        a_iv = 1'b0;
        for (int i = 0; i < 10 && !a_ov; i++) @(negedge clk);
        chk("fl_after_ov", a_ov, 1);
        chk("fl_after_pc", a_opc, 32'h2000);

        // DEPTH=2 capacity under full back-pressure.
        b_or = 1'b0;
        b_iv = 1'b1;
        idx = 0;
        acc_prev = 1'b0;
        stall_model = 0;
        for (int n = 0; n < 9; n++) begin
            if (n > 0) @(negedge clk);
            if (acc_prev) idx++;
            chk("cap_occ", b_occ, (n < 4) ? n : 4);
            chk("cap_ir", b_ir, n < 4);
            chk("cap_ov", b_ov, n >= 2);
            if (n >= 2) chk("cap_head", b_opc, 32'd100);
            if (b_ov && !b_or) stall_model++;
            b_ipc = 32'(100 + 4 * idx);
            b_id  = dat(b_ipc);
            acc_prev = b_iv && b_ir;
        end
        chk("cap_accepted", idx, 4);

        // Release: the four entries drain in order.
        b_or = 1'b1;
        b_iv = 1'b0;
        oidx = 0;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            if (b_ov) begin
                chk("drain_pc", b_opc, 32'(100 + 4 * oidx));
                chk("drain_dat", b_od, dat(32'(100 + 4 * oidx)));
                oidx++;
            end
        end
        chk("drain_cnt", oidx, 4);
        chk("drain_occ", b_occ, 0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("stall_cnt", b_stall, 32'(stall_model));
`endif

        // Asynchronous reset between edges with entries in flight.
        b_or = 1'b0;
        b_iv = 1'b1;
        for (int n = 0; n < 3; n++) begin
            b_ipc = 32'(200 + 4 * n);
            b_id  = dat(b_ipc);
            @(negedge clk);
        end
        chk("ar_pre_occ", b_occ, 3);
        chk("ar_pre_ov", b_ov, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ov", b_ov, 0);
        chk("ar_occ", b_occ, 0);
        chk("ar_ir", b_ir, 1);
        chk("ar_pc", b_opc, 0);
        @(negedge clk);
        rst  = 1'b0;
        b_iv = 1'b0;

        // Random valid/ready on DEPTH=3 against a FIFO scoreboard.
        pcn = 32'h3000;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            chk("rnd_occ", a_occ, q.size());
            ir_b = a_ir;
            a_or = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_ir_comb", a_ir, ir_b);
            a_iv  = 1'($urandom_range(0, 1));
            a_ipc = pcn;
            a_id  = dat(pcn);
            if (a_ov && a_or) begin
                chk("rnd_pc", a_opc, (q.size() > 0) ? q[0] : 32'hDEAD_BEEF);
                chk("rnd_dat", a_od, (q.size() > 0) ? dat(q[0]) : 64'h0);
                if (q.size() > 0) void'(q.pop_front());
            end
            if (a_iv && a_ir) begin
                q.push_back(pcn);
                pcn += 32'd4;
            end
        end
        @(negedge clk);
        a_iv = 1'b0;
        a_or = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_ov) begin
                chk("rnd_drain_pc", a_opc, (q.size() > 0) ? q[0] : 32'hDEAD_BEEF);
                if (q.size() > 0) void'(q.pop_front());
            end
            @(negedge clk);
        end
        chk("rnd_left", q.size(), 0);
        chk("rnd_occ_end", a_occ, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline register, replacing the fixed single-cycle IFID/IDEXE/EXEMEM/MEMWB style registers.
- Carries a PC word plus an arbitrary-width payload through DEPTH stages using a valid/ready handshake, so back-pressure is absorbed locally without a global stall wire.
- Supports a synchronous flush, used for branch-taken squash, that bubbles every in-flight entry.
- Sits between any two pipeline stages of the core (IF→ID, ID→EXE, EXE→MEM, MEM→WB).

Parameters:
- LEN, 32, PC width in bits.
- WIDTH, 64, payload width in bits (instruction plus control bundle).
- DEPTH, 1, number of chained register slots; legal 1..8.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous squash of all slots.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  chain accepts an entry this cycle.
- in_pc  input  LEN  PC of the incoming entry.
- in_data  input  WIDTH  payload of the incoming entry.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head entry.
- out_pc  output  LEN  PC of the head entry.
- out_data  output  WIDTH  payload of the head entry.
- occupancy  output  $clog2(2*DEPTH+1)  total valid entries held in the chain.

Behaviour:
- Reset is asynchronous and active-high, on the single clock: all valid bits clear, all data and PC registers clear to 0. Therefore out_valid=0, in_ready=1, out_pc=0, out_data=0 and occupancy=0 during and after reset.
- Each slot holds two entries: main (m_v, m_pc, m_data) and skid (s_v, s_pc, s_data).
  - Slot output is always main.
  - Slot in_ready equals !s_v, taken straight from a register, so there is no combinational path from out_ready to in_ready.
- Per slot, with acc = in_valid & in_ready and take = m_v & out_ready:
  - Case A, flush=1: m_v<=0 and s_v<=0. Data registers are don't-care. Flush overrides acc and take; an entry accepted in the flush cycle is discarded.
  - Case B, take or !m_v:
    - If s_v: main<=skid and s_v<=0.
    - Else: main<=in with m_v<=acc.
  - Case C, m_v & !take & acc: skid<=in and s_v<=1.
  - Otherwise: hold.
- Chaining: slot k out_* drives slot k+1 in_*. Chain in_* maps to slot 0; chain out_* maps to slot DEPTH-1.
- Latency: an entry accepted at edge t appears on out_valid after edge t+DEPTH-1; i.e. out_valid rises DEPTH cycles after acceptance when unstalled.
- Throughput: one entry per cycle with out_ready held at 1.
- Capacity: 2*DEPTH entries. in_ready drops exactly when the slot-0 skid is full.
- occupancy is the sum over slots of m_v+s_v, registered. It updates on the same edge as the valid bits.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Simultaneous acc and take on a full-main, empty-skid slot passes through with no skid use.
- If out_ready is deasserted mid-stream, entries back-fill the skids, then in_ready falls one cycle later.
- Payload and PC are never modified.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_PERF_EN.
- With the macro defined:
  - Adds outputs stall_cnt (32 bits), counting cycles with out_valid & !out_ready.
  - Adds flush_cnt (32 bits), accumulating occupancy sampled on every flush cycle.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Without it: the ports and counters are absent and the remaining behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - PIPE_DEPTH_MAX=8.
  - Occupancy-width function.
  - Typedef pipe_entry_t {pc, data} parametrised via LEN/WIDTH defaults.
- One sub-module, pipe_slot: a single two-entry skid slot with the same handshake ports minus occupancy. It also outputs its 2-bit count. pipe_stage_chain is a generate loop of DEPTH pipe_slot instances plus an occupancy adder.

Test Plan:
- Reset released with out_ready=1, DEPTH=3: drive in_pc=0,4,8,... every cycle → out_valid first at 3 cycles after the first accept, then out_pc=0,4,8 back-to-back with no bubbles.
- DEPTH=2, out_ready=0, in_valid held → exactly 4 entries accepted; in_ready=0 from the 5th cycle; occupancy=4. Release out_ready → entries emerge in order with no loss.
- flush asserted with occupancy=3 and in_valid=1 in the same cycle → next cycle out_valid=0, occupancy=0, and the flush-cycle entry never appears. With PERF_EN, flush_cnt=3.
- Random in_valid/out_ready at 50% each, 10k entries, DEPTH=1..4 → scoreboard shows in-order, lossless delivery, and in_ready never toggles combinationally with out_ready.
- reset asserted mid-stream asynchronously (between edges) → out_valid, occupancy and in_ready=1 take effect immediately, without waiting for a clock edge.
- With PERF_EN, out_valid=1 and out_ready=0 for 7 cycles → stall_cnt=7. Force the counter to 32'hFFFF_FFFE, then stall 3 cycles → holds at 32'hFFFF_FFFF.
